// File: rtl/dcache_ctrl_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache controller.
package dcache_ctrl_pkg;

  localparam int LINE_W = 64;
  localparam int STRB_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WB     = 3'd2,
    ST_REFILL = 3'd3,
    ST_FILL   = 3'd4
  } state_e;

  // Byte-wise merge: strobed bytes come from new_data, the rest keep old_data.
  function automatic logic [LINE_W-1:0] merge_bytes(input logic [LINE_W-1:0] old_data,
                                                    input logic [LINE_W-1:0] new_data,
                                                    input logic [STRB_W-1:0] strb);
    logic [LINE_W-1:0] res;
    res = old_data;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_data[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_data[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Tag, valid and dirty state per line; one combinational read index, one write port.
module dcache_tag_array #(
  parameter int NUM_LINES = 16,
  parameter int TAG_W     = 25
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(NUM_LINES)-1:0] rd_idx_i,
  output logic [TAG_W-1:0]             rd_tag_o,
  output logic                         rd_valid_o,
  output logic                         rd_dirty_o,
  input  logic                         wr_en_i,
  input  logic                         wr_dirty_only_i,
  input  logic [$clog2(NUM_LINES)-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]             wr_tag_i,
  input  logic                         wr_dirty_i
);

  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];

  // A store hit only marks the line dirty; a fill rewrites the whole entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i] <= '0;
      end
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en_i) begin
      if (wr_dirty_only_i) begin
        dirty_q[wr_idx_i] <= 1'b1;
      end else begin
        tag_q[wr_idx_i]   <= wr_tag_i;
        valid_q[wr_idx_i] <= 1'b1;
        dirty_q[wr_idx_i] <= wr_dirty_i;
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller, one 64-bit word per line.
// Drives an external one-hot-selected bank array whose read data arrives one cycle after access.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int NUM_LINES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_valid_i,
  output logic                 cpu_ready_o,
  input  logic                 cpu_we_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [LINE_W-1:0]    cpu_wdata_i,
  input  logic [STRB_W-1:0]    cpu_wstrb_i,
  output logic                 cpu_rvalid_o,
  output logic [LINE_W-1:0]    cpu_rdata_o,
  output logic                 bank_en_o,
  output logic                 bank_we_o,
  output logic [NUM_LINES-1:0] bank_sel_o,
  output logic [LINE_W-1:0]    bank_wdata_o,
  input  logic [LINE_W-1:0]    bank_rdata_i,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_W-1:0]    mem_wdata_o,
  input  logic [LINE_W-1:0]    mem_rdata_i
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = ADDR_W - 3 - INDEX_W;
  localparam logic [NUM_LINES-1:0] SEL_ONE = {{(NUM_LINES-1){1'b0}}, 1'b1};

  state_e              state_q;
  logic                req_we_q;
  logic [ADDR_W-4:0]   req_line_q;
  logic [LINE_W-1:0]   req_wdata_q;
  logic [STRB_W-1:0]   req_wstrb_q;
  logic [LINE_W-1:0]   fill_q;
  logic                cpu_ready_q;
  logic                mem_valid_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0]   mem_wdata_q;

  logic [INDEX_W-1:0]  cpu_idx_s;
  logic [INDEX_W-1:0]  req_idx_s;
  logic [TAG_W-1:0]    req_tag_s;
  logic [TAG_W-1:0]    rd_tag_s;
  logic                rd_valid_s;
  logic                rd_dirty_s;
  logic                hit_s;
  logic [LINE_W-1:0]   store_merge_s;
  logic                tag_wr_en_s;
  logic                tag_wr_dirty_only_s;
  logic                unused_addr_bits_s;

  assign cpu_idx_s          = cpu_addr_i[INDEX_W+2:3];
  assign req_idx_s          = req_line_q[INDEX_W-1:0];
  assign req_tag_s          = req_line_q[ADDR_W-4:INDEX_W];
  assign hit_s              = rd_valid_s && (rd_tag_s == req_tag_s);
  assign store_merge_s      = merge_bytes(bank_rdata_i, req_wdata_q, req_wstrb_q);
  assign unused_addr_bits_s = ^cpu_addr_i[2:0];

  assign cpu_ready_o = cpu_ready_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  dcache_tag_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W)
  ) u_tags (
    .clk             (clk),
    .rst_n           (rst_n),
    .rd_idx_i        (req_idx_s),
    .rd_tag_o        (rd_tag_s),
    .rd_valid_o      (rd_valid_s),
    .rd_dirty_o      (rd_dirty_s),
    .wr_en_i         (tag_wr_en_s),
    .wr_dirty_only_i (tag_wr_dirty_only_s),
    .wr_idx_i        (req_idx_s),
    .wr_tag_i        (req_tag_s),
    .wr_dirty_i      (req_we_q)
  );

  // Controller FSM with registered handshake and memory-bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_we_q    <= 1'b0;
      req_line_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      fill_q      <= '0;
      cpu_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_valid_i) begin
            req_we_q    <= cpu_we_i;
            req_line_q  <= cpu_addr_i[ADDR_W-1:3];
            req_wdata_q <= cpu_wdata_i;
            req_wstrb_q <= cpu_wstrb_i;
            cpu_ready_q <= 1'b0;
            state_q     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit_s) begin
            cpu_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (rd_valid_s && rd_dirty_s) begin
            // The victim word is only visible on bank_rdata now, so capture it for writeback.
            mem_valid_q <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {rd_tag_s, req_idx_s, 3'b000};
            mem_wdata_q <= bank_rdata_i;
            state_q     <= ST_WB;
          end else begin
            mem_valid_q <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {req_tag_s, req_idx_s, 3'b000};
            mem_wdata_q <= '0;
            state_q     <= ST_REFILL;
          end
        end
        ST_WB: begin
          if (mem_ready_i) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {req_tag_s, req_idx_s, 3'b000};
            mem_wdata_q <= '0;
            state_q     <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (mem_ready_i) begin
            fill_q      <= req_we_q ? merge_bytes(mem_rdata_i, req_wdata_q, req_wstrb_q)
                                    : mem_rdata_i;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            state_q     <= ST_FILL;
          end
        end
        ST_FILL: begin
          cpu_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          cpu_ready_q <= 1'b1;
          mem_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Bank access, CPU response and tag updates depend on same-cycle bank read data.
  always_comb begin
    bank_en_o           = 1'b0;
    bank_we_o           = 1'b0;
    bank_sel_o          = '0;
    bank_wdata_o        = '0;
    cpu_rvalid_o        = 1'b0;
    cpu_rdata_o         = '0;
    tag_wr_en_s         = 1'b0;
    tag_wr_dirty_only_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_valid_i) begin
          bank_en_o  = 1'b1;
          bank_sel_o = SEL_ONE << cpu_idx_s;
        end else begin
          bank_en_o = 1'b0;
        end
      end
      ST_LOOKUP: begin
        if (hit_s && req_we_q) begin
          bank_en_o           = 1'b1;
          bank_we_o           = 1'b1;
          bank_sel_o          = SEL_ONE << req_idx_s;
          bank_wdata_o        = store_merge_s;
          cpu_rvalid_o        = 1'b1;
          cpu_rdata_o         = store_merge_s;
          tag_wr_en_s         = 1'b1;
          tag_wr_dirty_only_s = 1'b1;
        end else if (hit_s) begin
          cpu_rvalid_o = 1'b1;
          cpu_rdata_o  = bank_rdata_i;
        end else begin
          cpu_rvalid_o = 1'b0;
        end
      end
      ST_FILL: begin
        bank_en_o    = 1'b1;
        bank_we_o    = 1'b1;
        bank_sel_o   = SEL_ONE << req_idx_s;
        bank_wdata_o = fill_q;
        cpu_rvalid_o = 1'b1;
        cpu_rdata_o  = fill_q;
        tag_wr_en_s  = 1'b1;
      end
      default: begin
        cpu_rvalid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed plus randomized bench for dcache_ctrl against a line-level cache and memory model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_valid, cpu_ready, cpu_we, cpu_rvalid;
  logic [31:0] cpu_addr;
  logic [63:0] cpu_wdata, cpu_rdata;
  logic [7:0]  cpu_wstrb;
  logic        bank_en, bank_we;
  logic [15:0] bank_sel;
  logic [63:0] bank_wdata, bank_rdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] bank_store [16];
  logic [24:0] ref_tag   [16];
  logic        ref_valid [16];
  logic        ref_dirty [16];
  logic [63:0] ref_data  [16];
  logic [63:0] mem_model [logic [31:0]];

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_valid_i  (cpu_valid),
    .cpu_ready_o  (cpu_ready),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_wstrb_i  (cpu_wstrb),
    .cpu_rvalid_o (cpu_rvalid),
    .cpu_rdata_o  (cpu_rdata),
    .bank_en_o    (bank_en),
    .bank_we_o    (bank_we),
    .bank_sel_o   (bank_sel),
    .bank_wdata_o (bank_wdata),
    .bank_rdata_i (bank_rdata),
    .mem_valid_o  (mem_valid),
    .mem_ready_i  (mem_ready),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  // Storage bank array: registered read of the selected word, optional write.
  always @(posedge clk) begin
    if (bank_en) begin
      for (int i = 0; i < 16; i++) begin
        if (bank_sel[i]) begin
          bank_rdata <= bank_store[i];
          if (bank_we) bank_store[i] <= bank_wdata;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_merge(input logic [63:0] old_d, input logic [63:0] new_d,
                                            input logic [7:0] strb);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = strb[b] ? new_d[8*b +: 8] : old_d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mem_get(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a, a ^ 32'hA5A5_5A5A};
  endfunction

  function automatic logic [15:0] onehot(input int idx);
    logic [15:0] v;
    v = 16'd0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // One CPU request; the bench plays memory with the given wait cycles per transaction.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wstrb, input int wbw, input int rfw);
    int          idx, n_tx, ti, wc, exp_lat;
    logic [24:0] tag;
    logic        hit, done;
    logic [63:0] exp_data;
    logic        t_we   [2];
    logic [31:0] t_addr [2];
    logic [63:0] t_wd   [2];
    logic [63:0] t_rd   [2];
    int          t_wait [2];
    idx  = int'(addr[6:3]);
    tag  = addr[31:7];
    hit  = ref_valid[idx] && (ref_tag[idx] == tag);
    n_tx = 0;
    if (hit) begin
      exp_data = we ? ref_merge(ref_data[idx], wdata, wstrb) : ref_data[idx];
      exp_lat  = 1;
      if (we) ref_dirty[idx] = 1'b1;
      ref_data[idx] = exp_data;
    end else begin
      if (ref_valid[idx] && ref_dirty[idx]) begin
        t_we[0]   = 1'b1;
        t_addr[0] = {ref_tag[idx], addr[6:3], 3'b000};
        t_wd[0]   = ref_data[idx];
        t_rd[0]   = 64'd0;
        t_wait[0] = wbw;
        mem_model[t_addr[0]] = ref_data[idx];
        n_tx = 1;
      end
      t_we[n_tx]   = 1'b0;
      t_addr[n_tx] = {addr[31:3], 3'b000};
      t_wd[n_tx]   = 64'd0;
      t_rd[n_tx]   = mem_get(t_addr[n_tx]);
      t_wait[n_tx] = rfw;
      exp_data = we ? ref_merge(t_rd[n_tx], wdata, wstrb) : t_rd[n_tx];
      exp_lat  = 3 + rfw + ((n_tx == 1) ? (1 + wbw) : 0);
      n_tx++;
      ref_tag[idx]   = tag;
      ref_valid[idx] = 1'b1;
      ref_dirty[idx] = we;
      ref_data[idx]  = exp_data;
    end

    @(negedge clk);
    cpu_valid = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
    mem_ready = 1'b0;
    #1;
    chk("accept_ready",  64'(cpu_ready), 64'd1);
    chk("accept_bank_en", 64'(bank_en), 64'd1);
    chk("accept_bank_we", 64'(bank_we), 64'd0);
    chk("accept_sel",    64'(bank_sel), 64'(onehot(idx)));

    ti = 0; wc = 0; done = 1'b0;
    for (int k = 1; k <= 80 && !done; k++) begin
      @(negedge clk);
      cpu_valid = 1'b0;
      cpu_wdata = {$urandom, $urandom};
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (mem_valid) begin
        if (ti >= n_tx) begin
          chk("unexpected_mem", 64'(mem_valid), 64'd0);
        end else begin
          chk("mem_we",   64'(mem_we), 64'(t_we[ti]));
          chk("mem_addr", 64'(mem_addr), 64'(t_addr[ti]));
          if (t_we[ti]) chk("mem_wdata", mem_wdata, t_wd[ti]);
          if (wc == t_wait[ti]) begin
            mem_ready = 1'b1;
            mem_rdata = t_rd[ti];
            ti++;
            wc = 0;
          end else begin
            wc++;
          end
        end
      end
      #1;
      if (!bank_en) chk("sel_when_idle", 64'(bank_sel), 64'd0);
      if (!cpu_rvalid) begin
        chk("busy_ready", 64'(cpu_ready), 64'd0);
      end else begin
        done = 1'b1;
        chk("latency",      64'(k), 64'(exp_lat));
        chk("rdata",        cpu_rdata, exp_data);
        chk("resp_ready",   64'(cpu_ready), 64'd0);
        chk("mem_txns",     64'(ti), 64'(n_tx));
        chk("resp_bank_en", 64'(bank_en), 64'(we || !hit));
        if (we || !hit) begin
          chk("resp_bank_we",    64'(bank_we), 64'd1);
          chk("resp_bank_wdata", bank_wdata, exp_data);
          chk("resp_bank_sel",   64'(bank_sel), 64'(onehot(idx)));
        end
      end
    end
    chk("resp_seen", 64'(done), 64'd1);
  endtask

  initial begin
    logic        seen;
    logic [31:0] ra;
    logic [3:0]  ri;
    rst_n = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0;
    cpu_wdata = 64'd0; cpu_wstrb = 8'd0; mem_ready = 1'b0; mem_rdata = 64'd0;
    for (int i = 0; i < 16; i++) begin
      ref_tag[i] = 25'd0; ref_valid[i] = 1'b0; ref_dirty[i] = 1'b0; ref_data[i] = 64'd0;
    end
    mem_model[32'h0000_0040] = 64'h1122_3344_5566_7788;
    mem_model[32'h0000_00C0] = 64'hCAFE_F00D_DEAD_BEEF;

    #12;
    chk("rst_cpu_ready",  64'(cpu_ready), 64'd1);
    chk("rst_mem_valid",  64'(mem_valid), 64'd0);
    chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    chk("rst_bank_en",    64'(bank_en), 64'd0);
    chk("rst_mem_addr",   64'(mem_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b0, 32'h0000_0040, 64'd0, 8'h00, 0, 1);
    do_req(1'b0, 32'h0000_0040, 64'd0, 8'h00, 0, 0);
    do_req(1'b1, 32'h0000_0040, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 0);
    do_req(1'b0, 32'h0000_0040, 64'd0, 8'h00, 0, 0);
    do_req(1'b0, 32'h0000_00C0, 64'd0, 8'h00, 2, 1);
    do_req(1'b0, 32'h0000_0140, 64'd0, 8'h00, 0, 10);

    // Reset while the refill request is outstanding.
    @(negedge clk);
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0240;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      cpu_valid = 1'b0;
      mem_ready = 1'b0;
      seen = mem_valid;
    end
    chk("rst_test_mem_valid", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_valid", 64'(mem_valid), 64'd0);
    chk("midrst_cpu_ready", 64'(cpu_ready), 64'd1);
    chk("midrst_bank_en",   64'(bank_en), 64'd0);
    for (int i = 0; i < 16; i++) begin
      ref_valid[i] = 1'b0; ref_dirty[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 32'h0000_0040, 64'd0, 8'h00, 0, 0);

    for (int n = 0; n < 150; n++) begin
      ri = 4'($urandom_range(0, 15));
      ra = {25'($urandom_range(0, 3)), ri, 3'($urandom)};
      do_req(1'($urandom), ra, {$urandom, $urandom}, 8'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache controller. It is the initiator side of the data_cache_bank storage interface: one-hot bank select, en/we, write data, and registered read data one cycle later. It sits between the LSU (CPU port) and the memory bus (mem port), and holds tag, valid and dirty state internally. One 64-bit word per line.

Parameters:
ADDR_W, 32, byte address width
NUM_LINES, 16, number of lines/banks (power of 2); INDEX_W = $clog2(NUM_LINES), TAG_W = ADDR_W-3-INDEX_W (localparams)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cpu_valid  in  1  request valid
cpu_ready  out  1  request accepted when valid&ready
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  byte address; [2:0] ignored
cpu_wdata  in  64  store data
cpu_wstrb  in  8  store byte strobes
cpu_rvalid  out  1  one-cycle response pulse (load data or store ack)
cpu_rdata  out  64  load data, valid with cpu_rvalid
bank_en  out  1  bank access enable
bank_we  out  1  bank write
bank_sel  out  NUM_LINES  one-hot bank select
bank_wdata  out  64  bank write data
bank_rdata  in  64  selected bank output, valid the cycle after a read/write access
mem_valid  out  1  memory request
mem_ready  in  1  memory accept; for reads, mem_rdata valid in the same cycle
mem_we  out  1  1=writeback, 0=refill
mem_addr  out  ADDR_W  line address, [2:0]=0
mem_wdata  out  64  writeback data
mem_rdata  in  64  refill data

Behaviour:
- Address split: index=addr[INDEX_W+2:3], tag=addr[ADDR_W-1:INDEX_W+3].
- Reset (async, rst_n low): state IDLE; valid[] and dirty[] cleared; request latches cleared; cpu_ready=1; all other outputs 0. Bank contents are not reset. Reset mid-operation aborts it immediately and mem_valid drops.
- IDLE: cpu_ready=1. On cpu_valid, latch we/addr/wdata/wstrb and drive bank_en=1, bank_we=0, bank_sel=onehot(index). Go to LOOKUP.
- LOOKUP: cpu_ready=0. hit = valid[idx] & tag[idx]==req_tag.
  - Load hit: cpu_rvalid=1, cpu_rdata=bank_rdata. Go to IDLE.
  - Store hit: bank write of merged data (per byte, wstrb ? wdata : bank_rdata); dirty[idx]=1; cpu_rvalid=1; cpu_rdata=merged. Go to IDLE.
  - Miss with valid&dirty: latch victim = bank_rdata. Go to WB.
  - Miss otherwise: go to REFILL.
- WB: mem_valid=1, mem_we=1, mem_addr={tag[idx],idx,3'b0}, mem_wdata=victim. Hold everything stable until mem_ready, then go to REFILL.
- REFILL: mem_valid=1, mem_we=0, mem_addr={req_tag,idx,3'b0}. Hold stable until mem_ready. On mem_ready, latch mem_rdata and go to FILL.
- FILL: bank write with line = refill data merged with store data if we, else refill data. Set tag[idx]=req_tag, valid[idx]=1, dirty[idx]=we. cpu_rvalid=1, cpu_rdata=line. Go to IDLE.
- Latency from accept: hit has response 1 cycle later. Clean miss has response N+2 cycles later, where N = cycles until mem_ready. Dirty miss adds the WB wait.
- cpu_rvalid has no backpressure. A new request is accepted at the earliest the cycle after a response.
- bank_en is high only in the IDLE-accept cycle, a store-hit LOOKUP, and FILL. bank_sel=0 whenever bank_en=0.
- mem_valid is never withdrawn before mem_ready, except on reset.

Decomposition:
- defines.v: state encodings (IDLE, LOOKUP, WB, REFILL, FILL), line width 64, strobe width 8.
- Sub-module dcache_tag_array: tag/valid/dirty registers with async active-low clear, one read index, one write port (set tag/valid/dirty, or set dirty only).
- A byte-merge function or small combinational block is shared by the LOOKUP and FILL paths.

Test Plan:
1. Reset, load 0x00000040 (idx 8), mem_ready after 2 cycles with mem_rdata=0x1122334455667788 -> mem read at 0x40; FILL writes bank_sel=1<<8; cpu_rdata=0x1122334455667788; cpu_rvalid 4 cycles after accept.
2. Load 0x00000040 again -> cpu_rvalid 1 cycle after accept with the same data; mem_valid stays 0.
3. Store 0x40, wdata=0xFFFFFFFFFFFFFFFF, wstrb=0x0F -> bank_wdata=0x11223344FFFFFFFF in LOOKUP; no memory traffic; following load returns 0x11223344FFFFFFFF.
4. Load 0x000000C0 (idx 8, new tag) -> writeback mem_we=1, addr 0x40, data 0x11223344FFFFFFFF; then refill at 0xC0; line 8 clean.
5. Hold mem_ready=0 for 10 cycles during REFILL -> mem_valid/mem_addr stable and cpu_ready=0 throughout; completes on the first mem_ready.
6. Assert rst_n=0 during REFILL wait -> mem_valid falls without waiting for clk, cpu_ready=1; after release, load 0x40 misses (valid cleared).
